// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM encoding.
// Imported by the control decoder and the execute stage so both agree on codes.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per cycle,
// WIDTH cycles per product, low WIDTH bits kept.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    count;
  logic             run;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  // product carries the last partial sum so the caller can register it on the done edge
  assign done     = run && (count == CW'(WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt, optional sequential MUL,
// valid/ready on both sides with registered result and flags.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             busy
);

  state_t state;
  state_t state_next;

  logic                    accept;
  logic                    is_mul;
  logic                    mul_start;
  logic                    mul_done;
  logic [WIDTH-1:0]        product;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH-1:0]        sum;
  logic [WIDTH-1:0]        diff;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_ovf;
  logic                    alu_ill;

  function automatic logic slt_fn(input logic signed [WIDTH-1:0] x,
                                  input logic signed [WIDTH-1:0] y);
    return x < y;
  endfunction

  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = MUL_EN && (alu_ctr == ALU_MUL);
  assign mul_start = accept && is_mul;
  assign busy      = (state != S_IDLE);

  assign a_s  = a;
  assign b_s  = b;
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (alu_ctr)
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_NOR: alu_res = ~(a | b);
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_fn(a_s, b_s)};
      default: alu_ill = 1'b1;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (mul_start) state_next = S_MUL;
      S_MUL:   if (mul_done)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // output stage: a new result may overwrite a result being drained at the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if ((state == S_MUL) && mul_done) begin
      out_valid <= 1'b1;
      result    <= product;
      zero      <= (product == '0);
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      zero      <= (alu_res == '0);
      overflow  <= alu_ovf;
      illegal   <= alu_ill;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: stimulus queues expected results, a monitor
// compares each delivered result; a MUL_EN=0 instance shares the stimulus.
module tb_alu_exec;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctr;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal;
  logic        busy;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] result2;
  logic        zero2;
  logic        overflow2;
  logic        illegal2;
  logic        busy2;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        i;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   checks;
  int   fails;

  alu_exec #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctr(alu_ctr), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .illegal(illegal), .busy(busy)
  );

  alu_exec #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .alu_ctr(alu_ctr), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
    .result(result2), .zero(zero2), .overflow(overflow2), .illegal(illegal2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result: got %h, required no result", result);
      end else begin
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("zero", {31'b0, zero}, {31'b0, e.z});
        chk("overflow", {31'b0, overflow}, {31'b0, e.o});
        chk("illegal", {31'b0, illegal}, {31'b0, e.i});
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic ez, input logic eo, input logic ei);
    logic ok;
    in_valid = 1'b1;
    alu_ctr  = op;
    a        = av;
    b        = bv;
    sb_q.push_back('{res: er, z: ez, o: eo, i: ei});
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got no accept, required accept of op %b", op);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    alu_ctr  = 4'b0000;
    a        = '0;
    b        = '0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    checks    = 0;
    fails     = 0;
    reset     = 1'b0;
    out_ready = 1'b1;
    idle();
    #1 reset = 1'b1;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'b0, zero, overflow, illegal, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1 chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // signed overflow on ADD, one-cycle latency
    drive(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    chk("add_latency", {31'b0, out_valid}, 32'd1);
    idle();
    settle();

    // back-to-back SUB then SLT with no bubble
    drive(4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("sub_valid", {31'b0, out_valid}, 32'd1);
    drive(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    chk("slt_no_bubble", {31'b0, out_valid}, 32'd1);
    drive(4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    drive(4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    idle();
    settle();

    // MUL: 32 busy cycles; the MUL_EN=0 instance flags the same code illegal
    drive(4'b1000, 32'h1234, 32'h10, 32'h12340, 1'b0, 1'b0, 1'b0);
    chk("nomul_illegal", {31'b0, illegal2}, 32'd1);
    chk("nomul_result", result2, 32'd0);
    chk("nomul_zero", {31'b0, zero2}, 32'd1);
    chk("nomul_valid", {31'b0, out_valid2}, 32'd1);
    idle();
    n = 0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      if (busy && !in_ready) n++;
      @(posedge clk); #1;
    end
    chk("mul_busy_cycles", n, 32'd32);
    drive(4'b1000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    idle();
    repeat (40) @(posedge clk);
    #1;

    // back-pressure hold, then drain and accept together
    out_ready = 1'b0;
    drive(4'b0000, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0, 1'b0);
    idle();
    settle();
    chk("hold_result", result, 32'h00F0);
    chk("hold_valid", {31'b0, out_valid}, 32'd1);
    chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    drive(4'b0001, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    chk("drain_next_result", result, 32'd3);
    chk("drain_next_valid", {31'b0, out_valid}, 32'd1);
    idle();
    settle();

    // unsupported code
    drive(4'b0011, 32'd7, 32'd9, 32'd0, 1'b1, 1'b0, 1'b1);
    idle();
    settle();

    // reset in the middle of a MUL discards it
    drive(4'b1000, 32'd3, 32'd3, 32'd9, 1'b0, 1'b0, 1'b0);
    idle();
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midmul_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("midmul_rst_result", result, 32'd0);
    chk("midmul_rst_flags", {28'b0, zero, overflow, illegal, busy}, 32'd0);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    @(negedge clk) reset = 1'b0;
    #1 chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drive(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    idle();

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    #1 chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
